// File: rtl/snake_game_ctrl_if.sv
// Bundle of game-control signals between the edge-detect stage and the game-control FSM.
//   Inputs to the FSM  : goodColl, badColl, button, direction[3:0]  (one-cycle pulses)
//   Outputs of the FSM : state[2:0], dir[3:0], length, score, move_tick, playing
// modport master : the producer side (drives pulses, observes game status)
// modport slave  : the game-control FSM
interface snake_game_ctrl_if #(
  parameter int unsigned LEN_W = 8
) ();
  logic             goodColl;
  logic             badColl;
  logic             button;
  logic [3:0]       direction;
  logic [2:0]       state;
  logic [3:0]       dir;
  logic [LEN_W-1:0] length;
  logic [LEN_W-1:0] score;
  logic             move_tick;
  logic             playing;

  modport master (
    output goodColl, badColl, button, direction,
    input  state, dir, length, score, move_tick, playing
  );

  modport slave (
    input  goodColl, badColl, button, direction,
    output state, dir, length, score, move_tick, playing
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Game-control FSM for the snake game.
// Consumes one-cycle pulses (food eaten, collision, button, one-hot direction), tracks the game
// state (IDLE/RUN/PAUSE/WIN/LOSE), the applied heading with reversal protection, the snake
// length and score, and produces the periodic move tick for the snake-body logic.
//
// Ports:
//   clk  : system clock, rising edge
//   nRst : asynchronous active-low reset
//   bus  : snake_game_ctrl_if.slave
//            in  goodColl, badColl, button, direction[3:0] ([3]=up [2]=down [1]=left [0]=right)
//            out state[2:0], dir[3:0], length, score, move_tick, playing (all registered)
//
// Optional feature macro SNAKE_SPEEDUP_EN: when defined, adds TICK_STEP / TICK_MIN and shortens
// the move-tick period on every food eaten, clamped at TICK_MIN.
module snake_game_ctrl #(
  parameter int unsigned START_LEN   = 2,
  parameter int unsigned MAX_LEN     = 50,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned TICK_W      = 25
`ifdef SNAKE_SPEEDUP_EN
  ,
  parameter int unsigned TICK_STEP   = 1_000_000,
  parameter int unsigned TICK_MIN    = 5_000_000
`endif
) (
  input logic               clk,
  input logic               nRst,
  snake_game_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StPause = 3'd2,
    StWin   = 3'd3,
    StLose  = 3'd4
  } state_e;

  localparam logic [3:0]        DirRight  = 4'b0001;
  localparam logic [LEN_W-1:0]  LenStart  = LEN_W'(START_LEN);
  localparam logic [LEN_W-1:0]  LenMax    = LEN_W'(MAX_LEN);
  localparam logic [TICK_W-1:0] TickLast  = TICK_W'(TICK_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        dir_q, dir_d;
  logic [3:0]        pend_q, pend_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  score_q, score_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic              playing_q, playing_d;

  logic [TICK_W-1:0] period_last;
  logic [LEN_W-1:0]  len_inc;
  logic [LEN_W-1:0]  score_inc;
  logic [3:0]        dir_opp;
  logic              dir_onehot;
  logic              dir_accept;
  logic              advance;

`ifdef SNAKE_SPEEDUP_EN
  localparam logic [TICK_W-1:0] TickStart = TICK_W'(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TickMinW  = TICK_W'(TICK_MIN);
  localparam logic [TICK_W-1:0] TickStepW = TICK_W'(TICK_STEP);

  logic [TICK_W-1:0] period_q, period_d;
  logic [TICK_W-1:0] period_dec;

  assign period_last = period_q - TICK_W'(1);
  // Shorten by one step unless that would drop below the floor.
  assign period_dec  = (period_q >= TickMinW && (period_q - TickMinW) >= TickStepW) ?
                       (period_q - TickStepW) : TickMinW;
`else
  assign period_last = TickLast;
`endif

  assign len_inc   = (len_q < LenMax) ? (len_q + LEN_W'(1)) : len_q;
  assign score_inc = (score_q < LenMax) ? (score_q + LEN_W'(1)) : score_q;

  // Reversal is judged against the heading actually applied, not the pending one.
  assign dir_opp    = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
  assign dir_onehot = (bus.direction != 4'd0) &&
                      ((bus.direction & (bus.direction - 4'd1)) == 4'd0);
  assign dir_accept = dir_onehot && (bus.direction != dir_opp);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    len_d    = len_q;
    score_d  = score_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    advance  = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
    period_d = period_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.button) begin
          state_d  = StRun;
          len_d    = LenStart;
          score_d  = '0;
          dir_d    = DirRight;
          pend_d   = DirRight;
          cnt_d    = '0;
`ifdef SNAKE_SPEEDUP_EN
          period_d = TickStart;
`endif
        end
      end

      StRun: begin
        if (dir_accept) begin
          pend_d = bus.direction;
        end
        if (bus.badColl) begin
          state_d = StLose;
          cnt_d   = '0;
        end else if (bus.goodColl) begin
          len_d   = len_inc;
          score_d = score_inc;
`ifdef SNAKE_SPEEDUP_EN
          period_d = period_dec;
`endif
          if (len_inc == LenMax) begin
            state_d = StWin;
            cnt_d   = '0;
          end else begin
            advance = 1'b1;
          end
        end else if (bus.button) begin
          // Counter holds so the tick phase resumes where it left off.
          state_d = StPause;
        end else begin
          advance = 1'b1;
        end

        // >= rather than == so a shortened period can never be overrun.
        if (advance) begin
          if (cnt_q >= period_last) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            dir_d  = pend_q;
          end else begin
            cnt_d = cnt_q + TICK_W'(1);
          end
        end
      end

      StPause: begin
        if (bus.button) begin
          state_d = StRun;
        end
      end

      StWin, StLose: begin
        cnt_d = '0;
        if (bus.button) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    playing_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= StIdle;
      dir_q     <= DirRight;
      pend_q    <= DirRight;
      len_q     <= '0;
      score_q   <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      len_q     <= len_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      playing_q <= playing_d;
    end
  end

`ifdef SNAKE_SPEEDUP_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      period_q <= TickStart;
    end else begin
      period_q <= period_d;
    end
  end
`endif

  assign bus.state     = state_q;
  assign bus.dir       = dir_q;
  assign bus.length    = len_q;
  assign bus.score     = score_q;
  assign bus.move_tick = tick_q;
  assign bus.playing   = playing_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: a behavioural game model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_snake_game_ctrl;

`ifdef SNAKE_SPEEDUP_EN
  localparam int TC   = 10;
  localparam int ML   = 6;
  localparam int STEP = 3;
  localparam int TMIN = 5;
`else
  localparam int TC   = 4;
  localparam int ML   = 4;
`endif
  localparam int SL = 2;

  logic clk;
  logic nRst;
  int   checks   = 0;
  int   failures = 0;

  snake_game_ctrl_if #(.LEN_W(8)) bus ();

  snake_game_ctrl #(
    .START_LEN  (SL),
    .MAX_LEN    (ML),
    .LEN_W      (8),
    .TICK_CYCLES(TC),
`ifdef SNAKE_SPEEDUP_EN
    .TICK_STEP  (STEP),
    .TICK_MIN   (TMIN),
`endif
    .TICK_W     (8)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  dir;
    logic [3:0]  pend;
    logic [31:0] len;
    logic [31:0] score;
    logic [31:0] cnt;
    logic [31:0] period;
    logic        tick;
  } mstate_t;

  mstate_t m;

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      4'b1000: return 4'b0100;
      4'b0100: return 4'b1000;
      4'b0010: return 4'b0001;
      4'b0001: return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic mstate_t step(input mstate_t c, input logic good, input logic bad,
                                   input logic btn, input logic [3:0] d);
    mstate_t n;
    bit      moving;
    int      p;
    n      = c;
    n.tick = 1'b0;
    moving = 1'b0;
    p      = 0;
    case (c.st)
      3'd0: if (btn) begin
        n.st = 3'd1; n.len = SL; n.score = 0; n.dir = 4'b0001; n.pend = 4'b0001;
        n.cnt = 0; n.period = TC;
      end
      3'd1: begin
        if ($countones(d) == 1 && d != opposite(c.dir)) n.pend = d;
        if (bad) begin
          n.st = 3'd4; n.cnt = 0;
        end else if (good) begin
          if (c.len < ML) n.len = c.len + 1;
          if (c.score < ML) n.score = c.score + 1;
`ifdef SNAKE_SPEEDUP_EN
          p = int'(c.period) - STEP;
          n.period = (p < TMIN) ? TMIN : p;
`endif
          if (n.len == ML) begin n.st = 3'd3; n.cnt = 0; end
          else moving = 1'b1;
        end else if (btn) begin
          n.st = 3'd2;
        end else begin
          moving = 1'b1;
        end
        if (moving) begin
          if (c.cnt + 1 >= c.period) begin
            n.cnt = 0; n.tick = 1'b1; n.dir = c.pend;
          end else begin
            n.cnt = c.cnt + 1;
          end
        end
      end
      3'd2: if (btn) n.st = 3'd1;
      default: begin
        n.cnt = 0;
        if (btn) n.st = 3'd0;
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m <= '{st: 3'd0, dir: 4'b0001, pend: 4'b0001, len: 0, score: 0, cnt: 0,
             period: TC, tick: 1'b0};
    end else begin
      m <= step(m, bus.goodColl, bus.badColl, bus.button, bus.direction);
    end
  end

  always @(negedge clk) begin
    if (nRst) begin
      chk("cyc_state", 32'(bus.state), 32'(m.st));
      chk("cyc_dir", 32'(bus.dir), 32'(m.dir));
      chk("cyc_length", 32'(bus.length), m.len);
      chk("cyc_score", 32'(bus.score), m.score);
      chk("cyc_move_tick", 32'(bus.move_tick), 32'(m.tick));
      chk("cyc_playing", 32'(bus.playing), 32'(m.st == 3'd1));
    end
  end

  // ---------------- stimulus helpers (each returns at posedge+2) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input logic g, input logic b, input logic bt, input logic [3:0] d);
    bus.goodColl  = g;
    bus.badColl   = b;
    bus.button    = bt;
    bus.direction = d;
    @(posedge clk);
    #2;
    bus.goodColl  = 1'b0;
    bus.badColl   = 1'b0;
    bus.button    = 1'b0;
    bus.direction = 4'd0;
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      idle(1);
      n++;
    end while (!bus.move_tick && n < budget);
    if (!bus.move_tick) begin
      checks++;
      failures++;
      $display("FAIL wait_tick actual=timeout required=move_tick within %0d cycles", budget);
    end
  endtask

  initial begin
    int n;
    int ticks;
    nRst          = 1'b0;
    bus.goodColl  = 1'b0;
    bus.badColl   = 1'b0;
    bus.button    = 1'b0;
    bus.direction = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_dir", 32'(bus.dir), 32'h1);
    chk("rst_length", 32'(bus.length), 0);
    chk("rst_tick", 32'(bus.move_tick), 0);
    nRst = 1'b1;
    idle(2);

    // 1: start, tick period
    pulse(1'b0, 1'b0, 1'b1, 4'd0);
    chk("start_state", 32'(bus.state), 1);
    chk("start_length", 32'(bus.length), SL);
    chk("start_score", 32'(bus.score), 0);
    chk("start_dir", 32'(bus.dir), 32'h1);
    chk("start_playing", 32'(bus.playing), 1);
    for (int k = 1; k <= 3 * TC; k++) begin
      idle(1);
      chk("tick_period", 32'(bus.move_tick), 32'(k % TC == 0));
    end

    // 2: up accepted, left rejected (opposite of applied right); down rejected after up applied
    pulse(1'b0, 1'b0, 1'b0, 4'b1000);
    pulse(1'b0, 1'b0, 1'b0, 4'b0010);
    wait_tick(2 * TC, n);
    chk("dir_up", 32'(bus.dir), 32'h8);
    pulse(1'b0, 1'b0, 1'b0, 4'b0100);
    wait_tick(2 * TC, n);
    chk("dir_reject_down", 32'(bus.dir), 32'h8);

    // 3: eat until WIN
    for (int k = 0; k <= ML - 3; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 4'd0);
      chk("eat_length", 32'(bus.length), 32'(3 + k));
      chk("eat_state", 32'(bus.state), (3 + k == ML) ? 3 : 1);
    end
    idle(2 * TC);
    pulse(1'b0, 1'b0, 1'b1, 4'd0);
    chk("win_ack_state", 32'(bus.state), 0);
    chk("win_ack_length", 32'(bus.length), ML);

    // 4: bad beats good; LOSE ignores further pulses
    pulse(1'b0, 1'b0, 1'b1, 4'd0);
    chk("restart_length", 32'(bus.length), SL);
    pulse(1'b1, 1'b1, 1'b0, 4'd0);
    chk("lose_state", 32'(bus.state), 4);
    chk("lose_length", 32'(bus.length), SL);
    pulse(1'b0, 1'b1, 1'b0, 4'b1000);
    chk("lose_hold_state", 32'(bus.state), 4);
    chk("lose_hold_dir", 32'(bus.dir), 32'h1);
    pulse(1'b0, 1'b0, 1'b1, 4'd0);
    chk("lose_ack_state", 32'(bus.state), 0);

    // 5: pause at counter 2, resume keeps phase
    pulse(1'b0, 1'b0, 1'b1, 4'd0);
    idle(2);
    pulse(1'b0, 1'b0, 1'b1, 4'd0);
    chk("pause_state", 32'(bus.state), 2);
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) pulse(1'b0, 1'b0, 1'b0, 4'b1000);
      else idle(1);
      ticks += int'(bus.move_tick);
    end
    chk("pause_no_tick", 32'(ticks), 0);
    pulse(1'b0, 1'b0, 1'b1, 4'd0);
    chk("resume_state", 32'(bus.state), 1);
    idle(TC - 3);
    chk("resume_tick_early", 32'(bus.move_tick), 0);
    idle(1);
    chk("resume_tick", 32'(bus.move_tick), 1);
    chk("resume_dir", 32'(bus.dir), 32'h1);

    // 6: asynchronous reset mid-game
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    chk("pre_rst_length", 32'(bus.length), 3);
    #1 nRst = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state), 0);
    chk("arst_dir", 32'(bus.dir), 32'h1);
    chk("arst_length", 32'(bus.length), 0);
    chk("arst_score", 32'(bus.score), 0);
    chk("arst_tick", 32'(bus.move_tick), 0);
    @(posedge clk);
    #2 nRst = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 4'd0);
    pulse(1'b0, 1'b0, 1'b0, 4'b0011);
    wait_tick(2 * TC, n);
    chk("multihot_ignored", 32'(bus.dir), 32'h1);

`ifdef SNAKE_SPEEDUP_EN
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    wait_tick(2 * TC, n);
    wait_tick(2 * TC, n);
    chk("speed_period1", 32'(n), 7);
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    wait_tick(2 * TC, n);
    wait_tick(2 * TC, n);
    chk("speed_period2", 32'(n), 5);
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    wait_tick(2 * TC, n);
    wait_tick(2 * TC, n);
    chk("speed_period3", 32'(n), 5);
`endif

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
